// File: rtl/cm0_bus_pkg.sv
// Shared types and widths for the cortex_m0 memory arbiter.
// Covers the owner/state encodings and the counter widths.
package cm0_bus_pkg;

  typedef enum logic {OWN_F = 1'b0, OWN_D = 1'b1} owner_e;
  typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} state_e;

  localparam int STARVE_W = 4;
  localparam int LAT_W    = 3;

endpackage

// File: rtl/cm0_mem_arbiter_if.sv
// Fetch, data and memory-side signals of the arbiter.
// The slave modport is the arbiter's view; the master modport is the requester/memory view.
interface cm0_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              f_req;
  logic [ADDR_W-1:0] f_addr;
  logic              f_gnt;
  logic              f_rvalid;
  logic [DATA_W-1:0] f_rdata;

  logic                d_req;
  logic                d_we;
  logic [ADDR_W-1:0]   d_addr;
  logic [DATA_W-1:0]   d_wdata;
  logic [DATA_W/8-1:0] d_be;
  logic                d_gnt;
  logic                d_rvalid;
  logic [DATA_W-1:0]   d_rdata;

  logic                mem_en;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W/8-1:0] mem_be;
  logic [DATA_W-1:0]   mem_rdata;

  logic busy;

  modport slave (
    input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata,
    output f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata, mem_be, busy
  );

  modport master (
    output f_req, f_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_rdata,
    input  f_gnt, f_rvalid, f_rdata, d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata, mem_be, busy
  );

endinterface

// File: rtl/cm0_mem_arbiter.sv
// Shares one fixed-latency memory port between fetch and load/store traffic.
// Data wins by default; a starvation counter forces a fetch grant after STARVE_MAX data wins.
module cm0_mem_arbiter
  import cm0_bus_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input logic              clk,
  input logic              rst,
  cm0_mem_arbiter_if.slave bus
);

  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);
  localparam logic [LAT_W-1:0]    LAT_INIT   = LAT_W'(MEM_LAT);

  state_e              state_q, state_d;
  owner_e              owner_q, owner_d;
  logic                isRead_q, isRead_d;
  logic [LAT_W-1:0]    latCnt_q, latCnt_d;
  logic [STARVE_W-1:0] starveCnt_q, starveCnt_d;

  logic respNow, canIssue, fWins, dWins, fGnt, dGnt, issue, respValid, dWrite;
  logic [ADDR_W-1:0] addrMux;
  logic [DATA_W-1:0] rdataMux;

  // A new access may start when idle or in the very cycle the old one returns.
  always_comb begin
    respNow  = (state_q == ST_WAIT) && (latCnt_q == LAT_W'(1));
    canIssue = !rst && ((state_q == ST_IDLE) || respNow);
    fWins    = bus.f_req && (!bus.d_req || (starveCnt_q == STARVE_LIM));
    dWins    = bus.d_req && !fWins;
    fGnt     = canIssue && fWins;
    dGnt     = canIssue && dWins;
    issue    = fGnt || dGnt;
    dWrite   = dGnt && bus.d_we;
    addrMux  = '0;
    if (fGnt) begin
      addrMux = bus.f_addr;
    end else if (dGnt) begin
      addrMux = bus.d_addr;
    end
    respValid = !rst && respNow && isRead_q;
    rdataMux  = bus.mem_rdata;
  end

  assign bus.f_gnt     = fGnt;
  assign bus.d_gnt     = dGnt;
  assign bus.mem_en    = issue;
  assign bus.mem_we    = dWrite;
  assign bus.mem_addr  = addrMux;
  assign bus.mem_wdata = dWrite ? bus.d_wdata : '0;
  assign bus.mem_be    = dWrite ? bus.d_be : '0;
  assign bus.f_rvalid  = respValid && (owner_q == OWN_F);
  assign bus.d_rvalid  = respValid && (owner_q == OWN_D);
  assign bus.f_rdata   = bus.f_rvalid ? rdataMux : '0;
  assign bus.d_rdata   = bus.d_rvalid ? rdataMux : '0;
  assign bus.busy      = !rst && (state_q == ST_WAIT);

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    isRead_d = isRead_q;
    latCnt_d = latCnt_q;
    if (issue) begin
      state_d  = ST_WAIT;
      owner_d  = fGnt ? OWN_F : OWN_D;
      isRead_d = fGnt || !bus.d_we;
      latCnt_d = LAT_INIT;
    end else if (respNow) begin
      state_d = ST_IDLE;
    end else if (state_q == ST_WAIT) begin
      latCnt_d = latCnt_q - LAT_W'(1);
    end
    // Counts data wins only while fetch is actually waiting.
    starveCnt_d = starveCnt_q;
    if (!bus.f_req || fGnt) begin
      starveCnt_d = '0;
    end else if (dGnt && (starveCnt_q != STARVE_LIM)) begin
      starveCnt_d = starveCnt_q + STARVE_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_F;
      isRead_q    <= 1'b0;
      latCnt_q    <= '0;
      starveCnt_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      isRead_q    <= isRead_d;
      latCnt_q    <= latCnt_d;
      starveCnt_q <= starveCnt_d;
    end
  end

endmodule

// File: tb/tb_cm0_mem_arbiter.sv
// Self-checking bench: transaction-level model of the arbiter for MEM_LAT=1 plus
// a second instance with MEM_LAT=3 for the latency scenario.
module tb_cm0_mem_arbiter;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;
  localparam int SMAX  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cm0_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) busA ();
  cm0_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) busB ();

  cm0_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT_A), .STARVE_MAX(SMAX)) dutA (
    .clk(clk), .rst(rst), .bus(busA)
  );
  cm0_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT_B), .STARVE_MAX(SMAX)) dutB (
    .clk(clk), .rst(rst), .bus(busB)
  );

  int total = 0;
  int bad   = 0;
  int cyc;

  logic [31:0] memArr   [256];
  logic [31:0] modelMem [256];
  logic [31:0] memRdNext;

  // Model: at most one access in flight, described by when it returns and to whom.
  bit          pendValid;
  int          pendDue;
  bit          pendF;
  bit          pendRead;
  logic [31:0] pendData;
  int          streak;

  logic        sFGnt, sDGnt, sFRv, sDRv, sMemEn, sMemWe, sBusy;
  logic [31:0] sFRd, sDRd, sMemAddr, sMemWd;
  logic [3:0]  sMemBe;

  function automatic logic [31:0] mergeBytes(input logic [31:0] oldW, input logic [31:0] newW,
                                             input logic [3:0] be);
    logic [31:0] r;
    r = oldW;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = newW[b*8 +: 8];
    return r;
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Compares dutA against the model, advances the model, and services dutA's memory.
  task automatic checkOutput();
    logic        eFG, eDG, eMemEn, eMemWe, eFRv, eDRv, eBusy;
    logic [31:0] eAddr, eWd, eFRd, eDRd;
    logic [3:0]  eBe;
    bit          respNow, canIss, fWin;
    int          idx;
    sFGnt = busA.f_gnt;  sDGnt = busA.d_gnt;  sFRv = busA.f_rvalid; sDRv = busA.d_rvalid;
    sMemEn = busA.mem_en; sMemWe = busA.mem_we; sBusy = busA.busy;
    sFRd = busA.f_rdata; sDRd = busA.d_rdata; sMemAddr = busA.mem_addr; sMemWd = busA.mem_wdata;
    sMemBe = busA.mem_be;
    {eFG, eDG, eMemEn, eMemWe, eFRv, eDRv, eBusy} = '0;
    {eAddr, eWd, eFRd, eDRd} = '0;
    eBe = '0;
    respNow = 0;
    if (!rst) begin
      respNow = pendValid && (pendDue == cyc);
      eBusy   = pendValid;
      canIss  = !pendValid || respNow;
      fWin    = busA.f_req && (!busA.d_req || streak >= SMAX);
      if (canIss && fWin) eFG = 1;
      else if (canIss && busA.d_req) eDG = 1;
      eMemEn = eFG | eDG;
      if (eFG) eAddr = busA.f_addr;
      if (eDG) begin
        eAddr = busA.d_addr;
        if (busA.d_we) begin
          eMemWe = 1; eWd = busA.d_wdata; eBe = busA.d_be;
        end
      end
      if (respNow && pendRead) begin
        if (pendF) begin eFRv = 1; eFRd = pendData; end
        else begin eDRv = 1; eDRd = pendData; end
      end
    end
    cmp("f_gnt", sFGnt, eFG);         cmp("d_gnt", sDGnt, eDG);
    cmp("mem_en", sMemEn, eMemEn);    cmp("mem_we", sMemWe, eMemWe);
    cmp("mem_addr", sMemAddr, eAddr); cmp("mem_wdata", sMemWd, eWd);
    cmp("mem_be", sMemBe, eBe);       cmp("busy", sBusy, eBusy);
    cmp("f_rvalid", sFRv, eFRv);      cmp("f_rdata", sFRd, eFRd);
    cmp("d_rvalid", sDRv, eDRv);      cmp("d_rdata", sDRd, eDRd);
    if (rst) begin
      pendValid = 0;
      streak    = 0;
    end else begin
      if (respNow) pendValid = 0;
      if (eMemEn) begin
        idx       = int'(eAddr[9:2]);
        pendValid = 1;
        pendDue   = cyc + LAT_A;
        pendF     = eFG;
        pendRead  = eFG || !busA.d_we;
        pendData  = modelMem[idx];
        if (eMemWe) modelMem[idx] = mergeBytes(modelMem[idx], eWd, eBe);
      end
      if (!busA.f_req || eFG) streak = 0;
      else if (eDG) streak = (streak + 1 > SMAX) ? SMAX : streak + 1;
    end
    if (busA.mem_en) begin
      idx = int'(busA.mem_addr[9:2]);
      if (busA.mem_we) memArr[idx] = mergeBytes(memArr[idx], busA.mem_wdata, busA.mem_be);
      else memRdNext = memArr[idx];
    end
  endtask

  task automatic stepCycle();
    @(negedge clk);
    checkOutput();
    @(posedge clk);
    #1;
    busA.mem_rdata = memRdNext;
    cyc++;
  endtask

  // Requesters only move on after a grant; occasional resets land anywhere.
  task automatic applyStimulus();
    if (!busA.f_req || sFGnt) begin
      busA.f_req  = ($urandom_range(0, 9) < 6);
      busA.f_addr = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
    end
    if (!busA.d_req || sDGnt) begin
      busA.d_req   = ($urandom_range(0, 9) < 6);
      busA.d_we    = 1'($urandom_range(0, 1));
      busA.d_addr  = {22'b0, 8'($urandom_range(0, 255)), 2'b00};
      busA.d_wdata = $urandom;
      busA.d_be    = 4'($urandom_range(1, 15));
    end
    rst = ($urandom_range(0, 149) == 0);
  endtask

  initial begin
    logic [9:0] seq;
    logic       expDG [5];
    logic       expFG [5];
    logic       expBs [5];
    logic       expRv [5];
    rst = 1'b1;
    busA.f_req = 0; busA.f_addr = '0; busA.d_req = 0; busA.d_we = 0;
    busA.d_addr = '0; busA.d_wdata = '0; busA.d_be = '0; busA.mem_rdata = '0;
    busB.f_req = 0; busB.f_addr = '0; busB.d_req = 0; busB.d_we = 0;
    busB.d_addr = '0; busB.d_wdata = '0; busB.d_be = '0; busB.mem_rdata = 32'hB0B0_0003;
    for (int i = 0; i < 256; i++) begin
      memArr[i]   = 32'hC0DE_0000 | 32'(i);
      modelMem[i] = 32'hC0DE_0000 | 32'(i);
    end
    memRdNext = '0; pendValid = 0; pendDue = 0; pendF = 0; pendRead = 0; pendData = '0;
    streak = 0; cyc = 0;
    {sFGnt, sDGnt} = '0;
    @(posedge clk); #1;

    stepCycle();
    cmp("rst_outputs_zero", {26'b0, sFGnt, sDGnt, sMemEn, sFRv, sDRv, sBusy}, 32'h0);
    rst = 1'b0;

    busA.f_req = 1; busA.f_addr = 32'h100;
    stepCycle();
    cmp("lone_f_gnt", sFGnt, 1); cmp("lone_f_addr", sMemAddr, 32'h100);
    busA.f_req = 0;
    stepCycle();
    cmp("lone_f_rvalid", sFRv, 1); cmp("lone_f_rdata", sFRd, 32'hC0DE_0040);

    busA.d_req = 1; busA.d_we = 0; busA.d_addr = 32'h10;
    stepCycle();
    cmp("midrd_gnt", sDGnt, 1);
    busA.d_req = 0; rst = 1;
    stepCycle();
    cmp("midrd_in_rst", {28'b0, sDRv, sFRv, sMemEn, sBusy}, 32'h0);
    rst = 0;
    stepCycle();
    cmp("midrd_no_late_rvalid", {29'b0, sDRv, sFRv, sBusy}, 32'h0);

    busA.f_req = 1; busA.f_addr = 32'h300; busA.d_req = 1; busA.d_we = 0; busA.d_addr = 32'h200;
    stepCycle();
    cmp("cont_d_gnt", sDGnt, 1); cmp("cont_f_gnt", sFGnt, 0);
    busA.d_req = 0;
    stepCycle();
    cmp("cont_d_rvalid", sDRv, 1); cmp("cont_d_rdata", sDRd, 32'hC0DE_0080);
    cmp("cont_f_gnt_next", sFGnt, 1);
    busA.f_req = 0;
    stepCycle();
    cmp("cont_f_rdata", sFRd, 32'hC0DE_00C0);

    seq = '0;
    busA.f_addr = 32'h400; busA.d_addr = 32'h500; busA.d_we = 0;
    for (int i = 0; i < 10; i++) begin
      busA.f_req = 1; busA.d_req = 1;
      stepCycle();
      seq[i] = sFGnt;
      if (sFGnt) busA.f_addr = busA.f_addr + 32'h4;
      if (sDGnt) busA.d_addr = busA.d_addr + 32'h4;
    end
    cmp("starve_seq", {22'b0, seq}, 32'b10_0001_0000);
    busA.f_req = 0; busA.d_req = 0;
    stepCycle();

    busA.d_req = 1; busA.d_we = 1; busA.d_addr = 32'h40; busA.d_wdata = 32'hDEAD_BEEF; busA.d_be = 4'hF;
    stepCycle();
    cmp("wr_mem_we", sMemWe, 1); cmp("wr_mem_wdata", sMemWd, 32'hDEAD_BEEF);
    cmp("wr_mem_addr", sMemAddr, 32'h40); cmp("wr_mem_be", sMemBe, 32'hF);
    busA.d_we = 0;
    stepCycle();
    cmp("wr_no_rvalid", sDRv, 0); cmp("rd_after_wr_gnt", sDGnt, 1);
    busA.d_req = 0;
    stepCycle();
    cmp("rd_after_wr_rvalid", sDRv, 1); cmp("rd_after_wr_data", sDRd, 32'hDEAD_BEEF);

    for (int i = 0; i < 3000; i++) begin
      applyStimulus();
      stepCycle();
    end
    rst = 0; busA.f_req = 0; busA.d_req = 0;
    stepCycle();
    stepCycle();

    expDG = '{1, 0, 0, 0, 0};
    expFG = '{0, 0, 0, 1, 0};
    expBs = '{0, 1, 1, 1, 1};
    expRv = '{0, 0, 0, 1, 0};
    busB.d_req = 1; busB.d_we = 0; busB.d_addr = 32'h20;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      cmp("lat3_d_gnt", busB.d_gnt, expDG[k]);
      cmp("lat3_f_gnt", busB.f_gnt, expFG[k]);
      cmp("lat3_busy", busB.busy, expBs[k]);
      cmp("lat3_d_rvalid", busB.d_rvalid, expRv[k]);
      if (k == 3) cmp("lat3_d_rdata", busB.d_rdata, 32'hB0B0_0003);
      @(posedge clk); #1;
      if (k == 0) begin busB.d_req = 0; busB.f_req = 1; busB.f_addr = 32'h24; end
      if (k == 3) busB.f_req = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cm0_mem_arbiter.md
# cm0_mem_arbiter

Two-requester arbiter sharing the cortex_m0 core's single-port memory between the instruction-fetch path and the load/store path. It sits between the core's fetch and data ports and one memory instance of fixed read latency. It grants one access at a time and tracks the outstanding owner so read data returns to the correct requester. Data accesses have priority, bounded by a starvation counter that guarantees fetch progress.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LAT, 1, cycles from mem_en to valid mem_rdata; legal 1..4
- STARVE_MAX, 4, consecutive data grants tolerated while fetch waits; legal 1..15
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- f_req  in  1  fetch request; held until f_gnt
- f_addr  in  ADDR_W  fetch address
- f_gnt  out  1  fetch accepted this cycle
- f_rvalid  out  1  fetch read data valid
- f_rdata  out  DATA_W  fetch read data
- d_req  in  1  data request; held until d_gnt
- d_we  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_be  in  DATA_W/8  byte enables, writes only
- d_gnt  out  1  data accepted this cycle
- d_rvalid  out  1  data read valid; never asserted for writes
- d_rdata  out  DATA_W  data read data
- mem_en, mem_we  out  1  memory strobe and write enable
- mem_addr  out  ADDR_W; mem_wdata  out  DATA_W; mem_be  out  DATA_W/8
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  an access is outstanding

## Operation
- FSM states: IDLE (no access outstanding) and WAIT (access outstanding, latency counter running).
- Issue slot: the arbiter may issue in IDLE, or in the WAIT cycle in which the outstanding response returns. Issue drives mem_en=1, the winner's fields onto mem_*, and the winner's gnt=1, all combinationally in the same cycle. The loser's gnt=0. Fetch issues have mem_we=0 and mem_be=0.
- Arbitration: d wins when d_req=1, unless f_req=1 and starve_cnt==STARVE_MAX, in which case f wins. Otherwise the sole requester wins.
- starve_cnt (4 bits): increments on a d grant while f_req=1. It clears on any f grant, or on any cycle with f_req=0. It saturates at STARVE_MAX.
- On issue, the arbiter registers the owner (F/D) and is_read, loads the latency counter with MEM_LAT, and enters WAIT.
- Response: in the cycle the counter expires, the owner's rvalid=1 if is_read, and rdata=mem_rdata passes through combinationally. The non-owner's rvalid=0. If no new issue occurs in that cycle, the FSM returns to IDLE.
- f_rdata and d_rdata are 0 whenever the corresponding rvalid=0.
- Requesters drop or change req only after seeing gnt. The arbiter does not check this.

## Timing
- Reset values: state IDLE, starve_cnt 0, owner F. All outputs are 0.
- While rst=1, gnt, mem_en and rvalid are forced 0 combinationally.
- Reset mid-access abandons the outstanding access. No rvalid is ever delivered for it.
- Read latency from gnt cycle t to rvalid cycle: t+MEM_LAT.
- Throughput with MEM_LAT=1: one access per cycle, with back-to-back issue in the response cycle.
- Throughput in general: one access per MEM_LAT cycles.
- busy=1 from the cycle after issue through the response cycle. It stays 1 across back-to-back issues.
- Simultaneous requests in IDLE: only one gnt per cycle, ever.
- Simultaneous response and new issue in the same cycle: rvalid belongs to the old owner, gnt to the new one.
- Write then read to the same address in back-to-back issues: the memory resolves ordering. The arbiter preserves issue order.

## Structure
- Shared package cm0_bus_pkg holds:
  - owner enum {OWN_F, OWN_D}
  - state enum {ST_IDLE, ST_WAIT}
  - STARVE_W = 4
  - lat counter width = 3
- Single module. The starvation counter and latency counter are inline registers; no sub-module.

## Test plan
All scenarios use MEM_LAT=1 and STARVE_MAX=4.
- Reset: assert rst mid-read. Next cycle all outputs are 0 and no f_rvalid/d_rvalid follows. After release, a lone f_req at 0x100 gives f_gnt in the same cycle and f_rvalid next cycle with mem_rdata.
- Contention: f_req and d_req (read, 0x200) are both high in IDLE. d_gnt=1, f_gnt=0. The next cycle gives d_rvalid=1 and f_gnt=1 in the same cycle.
- Starvation: f_req and d_req are held high for 10 cycles. Grants follow D,D,D,D,F,D,D,D,D,F.
- Write: d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF, d_be=0xF. mem_we=1 with the same fields, and d_rvalid stays 0. A following read of 0x40 returns 0xDEADBEEF on d_rdata.
- Latency: with MEM_LAT=3, a read granted at cycle t gives rvalid at t+3 and the next gnt no earlier than t+3. busy is high over t+1..t+3.
